// File: rtl/ars_mod_inv_if.sv
// rtl/ars_mod_inv_if.sv - operand/result bundle for the GF(2^233) inverter
interface ars_mod_inv_if #(
    parameter int WIDTH = 233,
    parameter int CNT_W = 10
);
    logic [WIDTH-1:0] DIN;
    logic             IN_VALID;
    logic [WIDTH-1:0] DOUT;
    logic             OUT_VALID;
    logic             BUSY;
    logic             ZERO_ERR;
    logic [CNT_W-1:0] CYC_CNT;

    modport master (
        output DIN, IN_VALID,
        input  DOUT, OUT_VALID, BUSY, ZERO_ERR, CYC_CNT
    );

    modport slave (
        input  DIN, IN_VALID,
        output DOUT, OUT_VALID, BUSY, ZERO_ERR, CYC_CNT
    );
endinterface

// File: rtl/ars_mod_inv.sv
// rtl/ars_mod_inv.sv - bit-serial binary extended-Euclid inverter over GF(2^233)
module ars_mod_inv #(
    parameter int WIDTH    = 233,
    parameter int POLY_MID = 74,
    parameter int CNT_W    = 10
) (
    input  logic           CLK,
    input  logic           RST_N,
    ars_mod_inv_if.slave   bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [WIDTH:0]   F_POLY  = ((WIDTH+1)'(1) << WIDTH) | ((WIDTH+1)'(1) << POLY_MID)
                                          | (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] G_ONE   = WIDTH'(1);
    // Dividing the x^0 term of f by x leaves x^(POLY_MID-1) and x^(WIDTH-1)
    localparam logic [WIDTH-1:0] MID_BIT = WIDTH'(1) << (POLY_MID - 1);

    function automatic logic [WIDTH-1:0] div_x(input logic [WIDTH-1:0] g);
        if (g[0]) return {1'b1, g[WIDTH-1:1]} ^ MID_BIT;
        else      return {1'b0, g[WIDTH-1:1]};
    endfunction

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] u_q, u_d;
    logic [WIDTH:0]   v_q, v_d;
    logic [WIDTH-1:0] g1_q, g1_d;
    logic [WIDTH-1:0] g2_q, g2_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             zero_q, zero_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        u_d     = u_q;
        v_d     = v_q;
        g1_d    = g1_q;
        g2_d    = g2_q;
        dout_d  = dout_q;
        zero_d  = zero_q;
        cnt_d   = cnt_q;
        if (bus.IN_VALID) begin
            u_d    = bus.DIN;
            v_d    = F_POLY;
            g1_d   = G_ONE;
            g2_d   = '0;
            cnt_d  = '0;
            zero_d = (bus.DIN == '0);
            if (bus.DIN == '0) begin
                dout_d  = '0;
                state_d = S_DONE;
            end else begin
                state_d = S_RUN;
            end
        end else begin
            case (state_q)
                S_RUN: begin
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    if (u_q == G_ONE) begin
                        dout_d  = g1_q;
                        state_d = S_DONE;
                    end else if (v_q == (WIDTH+1)'(1)) begin
                        dout_d  = g2_q;
                        state_d = S_DONE;
                    end else if (!u_q[0]) begin
                        u_d  = u_q >> 1;
                        g1_d = div_x(g1_q);
                    end else if (!v_q[0]) begin
                        v_d  = v_q >> 1;
                        g2_d = div_x(g2_q);
                    end else if ({1'b0, u_q} > v_q) begin
                        u_d  = u_q ^ v_q[WIDTH-1:0];
                        g1_d = g1_q ^ g2_q;
                    end else begin
                        v_d  = v_q ^ {1'b0, u_q};
                        g2_d = g2_q ^ g1_q;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            u_q     <= '0;
            v_q     <= '0;
            g1_q    <= '0;
            g2_q    <= '0;
            dout_q  <= '0;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            u_q     <= u_d;
            v_q     <= v_d;
            g1_q    <= g1_d;
            g2_q    <= g2_d;
            dout_q  <= dout_d;
            zero_q  <= zero_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.DOUT      = dout_q;
    assign bus.OUT_VALID = (state_q == S_DONE);
    assign bus.BUSY      = (state_q == S_RUN);
    assign bus.ZERO_ERR  = (state_q == S_DONE) && zero_q;
    assign bus.CYC_CNT   = cnt_q;
endmodule
